// File: rtl/opera_bus_pkg.sv
// Shared types and address map for the Opera bus controller.
// Used by the decoder, the controller and any simulation monitors.
package opera_bus_pkg;

    typedef enum logic [2:0] {
        RGN_MADAM,
        RGN_CLIO,
        RGN_SVF,
        RGN_SVF2,
        RGN_EXT
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EXT,
        ACK
    } state_e;

    localparam logic [31:0] MADAM_BASE  = 32'h0330_0000;
    localparam logic [31:0] MADAM_LIMIT = 32'h0330_FFFF;
    localparam logic [31:0] CLIO_BASE   = 32'h0340_0000;
    localparam logic [31:0] CLIO_LIMIT  = 32'h0340_FFFF;
    localparam logic [31:0] SVF_ADR0    = 32'h0320_6100;
    localparam logic [31:0] SVF_ADR1    = 32'h0320_6900;
    localparam logic [31:0] SVF2_ADR    = 32'h0320_02B4;

    localparam logic [31:0] SVF_DATA_DEF = 32'hBADA_CCE5;
    localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/opera_addr_decode.sv
// Combinational CPU address to target region decode.
module opera_addr_decode
    import opera_bus_pkg::*;
(
    input  logic [31:0] adr_i,
    output region_e     region_o
);

    always_comb begin
        region_o = RGN_EXT;
        if (in_range(adr_i, MADAM_BASE, MADAM_LIMIT)) begin
            region_o = RGN_MADAM;
        end else if (in_range(adr_i, CLIO_BASE, CLIO_LIMIT)) begin
            region_o = RGN_CLIO;
        end else if ((adr_i == SVF_ADR0) || (adr_i == SVF_ADR1)) begin
            region_o = RGN_SVF;
        end else if (adr_i == SVF2_ADR) begin
            region_o = RGN_SVF2;
        end
    end

endmodule

// File: rtl/opera_bus_ctrl.sv
// Wishbone slave controller: decodes CPU cycles to MADAM/CLIO/stubs/external memory,
// inserts per-target wait states, registers read data and times out external cycles.
module opera_bus_ctrl
    import opera_bus_pkg::*;
#(
    parameter int unsigned MADAM_WS = 1,
    parameter int unsigned CLIO_WS  = 2,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] SVF_DATA = SVF_DATA_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    input  logic [3:0]  wb_sel,
    output logic        wb_ack,
    output logic [31:0] wb_dat_r,
    output logic        madam_rd,
    output logic        madam_wr,
    input  logic [31:0] madam_dout,
    output logic        clio_rd,
    output logic        clio_wr,
    input  logic [31:0] clio_dout,
    output logic [31:0] tgt_adr,
    output logic [31:0] tgt_dat,
    output logic [3:0]  tgt_sel,
    output logic        ext_stb,
    output logic        ext_we,
    input  logic        ext_ack,
    input  logic [31:0] ext_dat,
    input  logic        err_clr,
    output logic        bus_err,
    output logic [31:0] err_adr
);

    localparam logic [7:0] MADAM_WS_C = 8'(MADAM_WS);
    localparam logic [7:0] CLIO_WS_C  = 8'(CLIO_WS);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    region_e     rgn_q, rgn_d, rgn_dec;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdat_q, rdat_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_adr_q, err_adr_d;
    logic [7:0]  ws_sel;
    logic        first_wait;

    opera_addr_decode u_decode (
        .adr_i    (wb_adr),
        .region_o (rgn_dec)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rgn_q     <= RGN_EXT;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rdat_q    <= '0;
            bus_err_q <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            rgn_q     <= rgn_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rdat_q    <= rdat_d;
            bus_err_q <= bus_err_d;
            err_adr_q <= err_adr_d;
        end
    end

    // WAIT counts down from the target's wait count; EXT counts up toward the timeout.
    always_comb begin
        state_d   = state_q;
        rgn_d     = rgn_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rdat_d    = rdat_q;
        bus_err_d = err_clr ? 1'b0 : bus_err_q;
        err_adr_d = err_adr_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d = wb_adr;
                    dat_d = wb_dat_w;
                    sel_d = wb_sel;
                    we_d  = wb_we;
                    rgn_d = rgn_dec;
                    case (rgn_dec)
                        RGN_MADAM: begin
                            state_d = WAIT;
                            cnt_d   = MADAM_WS_C;
                        end
                        RGN_CLIO: begin
                            state_d = WAIT;
                            cnt_d   = CLIO_WS_C;
                        end
                        RGN_SVF: begin
                            state_d = ACK;
                            if (!wb_we) rdat_d = SVF_DATA;
                        end
                        RGN_SVF2: begin
                            state_d = ACK;
                            if (!wb_we) rdat_d = '0;
                        end
                        default: begin
                            state_d = EXT;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (!we_q) rdat_d = (rgn_q == RGN_MADAM) ? madam_dout : clio_dout;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EXT: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (ext_ack) begin
                    if (!we_q) rdat_d = ext_dat;
                    state_d = ACK;
                end else if (cnt_q == TO_LAST) begin
                    if (!we_q) rdat_d = ERR_DATA;
                    if (!err_clr) begin
                        bus_err_d = 1'b1;
                        if (!bus_err_q) err_adr_d = adr_q;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ws_sel     = (rgn_q == RGN_MADAM) ? MADAM_WS_C : CLIO_WS_C;
    assign first_wait = (state_q == WAIT) && (cnt_q == ws_sel);

    always_comb begin
        wb_ack   = (state_q == ACK);
        madam_rd = first_wait && (rgn_q == RGN_MADAM) && !we_q;
        madam_wr = first_wait && (rgn_q == RGN_MADAM) &&  we_q;
        clio_rd  = first_wait && (rgn_q == RGN_CLIO)  && !we_q;
        clio_wr  = first_wait && (rgn_q == RGN_CLIO)  &&  we_q;
        ext_stb  = (state_q == EXT);
        ext_we   = (state_q == EXT) && we_q;
    end

    assign wb_dat_r = rdat_q;
    assign tgt_adr  = adr_q;
    assign tgt_dat  = dat_q;
    assign tgt_sel  = sel_q;
    assign bus_err  = bus_err_q;
    assign err_adr  = err_adr_q;

endmodule

// File: tb/tb_opera_bus_ctrl.sv
// Bench for opera_bus_ctrl: transaction-level model scheduling expected outputs per cycle,
// a per-cycle compare process, and literal expectations for the key scenarios.
module tb_opera_bus_ctrl;

    localparam int TB_MWS = 1;
    localparam int TB_CWS = 2;
    localparam int TB_TO  = 4;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic [31:0] wb_dat_r;
    logic        madam_rd, madam_wr, clio_rd, clio_wr;
    logic [31:0] madam_dout, clio_dout;
    logic [31:0] tgt_adr, tgt_dat;
    logic [3:0]  tgt_sel;
    logic        ext_stb, ext_we, ext_ack;
    logic [31:0] ext_dat;
    logic        err_clr, bus_err;
    logic [31:0] err_adr;

    opera_bus_ctrl #(
        .MADAM_WS (TB_MWS),
        .CLIO_WS  (TB_CWS),
        .TIMEOUT  (TB_TO),
        .SVF_DATA (32'hBADACCE5),
        .ERR_DATA (32'hFFFFFFFF)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_dat_w   (wb_dat_w),
        .wb_sel     (wb_sel),
        .wb_ack     (wb_ack),
        .wb_dat_r   (wb_dat_r),
        .madam_rd   (madam_rd),
        .madam_wr   (madam_wr),
        .madam_dout (madam_dout),
        .clio_rd    (clio_rd),
        .clio_wr    (clio_wr),
        .clio_dout  (clio_dout),
        .tgt_adr    (tgt_adr),
        .tgt_dat    (tgt_dat),
        .tgt_sel    (tgt_sel),
        .ext_stb    (ext_stb),
        .ext_we     (ext_we),
        .ext_ack    (ext_ack),
        .ext_dat    (ext_dat),
        .err_clr    (err_clr),
        .bus_err    (bus_err),
        .err_adr    (err_adr)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc_n = 0;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // One scheduled CPU transaction, in absolute cycle numbers (cycle n = after the n-th rising edge).
    typedef struct {
        int          E;        // cycle after the sampling edge
        int          endc;     // ack cycle, or last cycle before abort takes effect
        int          ext_last; // last cycle ext_stb is expected high
        int          rgn;      // 0 madam, 1 clio, 2 svf, 3 svf2, 4 ext
        bit          we;
        bit          acks;
        bit          tmo;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [3:0]  sel;
    } txn_t;

    txn_t        q[$];
    int          free_at = 0;
    int          clr_at  = -1;
    logic [31:0] m_dat, m_eadr, m_tadr, m_tdat;
    logic [3:0]  m_tsel;
    logic        m_err;

    function automatic int tb_region(input logic [31:0] a);
        if (a >= 32'h0330_0000 && a <= 32'h0330_FFFF) return 0;
        if (a >= 32'h0340_0000 && a <= 32'h0340_FFFF) return 1;
        if (a == 32'h0320_6100 || a == 32'h0320_6900) return 2;
        if (a == 32'h0320_02B4) return 3;
        return 4;
    endfunction

    task automatic model_reset();
        q.delete();
        m_dat  = '0;
        m_eadr = '0;
        m_tadr = '0;
        m_tdat = '0;
        m_tsel = '0;
        m_err  = 1'b0;
        clr_at = -1;
    endtask

    always @(negedge sys_clk) begin
        logic [3:0] e_str;
        logic       e_ack, e_stb, e_we;
        txn_t       t;
        e_str = '0;
        e_ack = 1'b0;
        e_stb = 1'b0;
        e_we  = 1'b0;
        if (q.size() > 0) begin
            t = q[0];
            if (cyc_n == t.E) begin
                m_tadr = t.adr;
                m_tdat = t.wdat;
                m_tsel = t.sel;
                if (t.rgn == 0) e_str = t.we ? 4'b0100 : 4'b1000;
                if (t.rgn == 1) e_str = t.we ? 4'b0001 : 4'b0010;
            end
            if (t.rgn == 4 && cyc_n >= t.E && cyc_n <= t.ext_last) begin
                e_stb = 1'b1;
                e_we  = t.we;
            end
            if (t.acks && cyc_n == t.endc) begin
                e_ack = 1'b1;
                if (!t.we) m_dat = t.rdat;
                if (t.tmo && clr_at != cyc_n) begin
                    if (!m_err) m_eadr = t.adr;
                    m_err = 1'b1;
                end
            end
            if (cyc_n >= t.endc) void'(q.pop_front());
        end
        if (clr_at == cyc_n) m_err = 1'b0;

        check("wb_ack",   {31'b0, wb_ack}, {31'b0, e_ack});
        check("strobes",  {28'b0, madam_rd, madam_wr, clio_rd, clio_wr}, {28'b0, e_str});
        check("ext_stb_we", {30'b0, ext_stb, ext_we}, {30'b0, e_stb, e_we});
        check("wb_dat_r", wb_dat_r, m_dat);
        check("tgt_adr",  tgt_adr, m_tadr);
        check("tgt_dat",  tgt_dat, m_tdat);
        check("tgt_sel",  {28'b0, tgt_sel}, {28'b0, m_tsel});
        check("bus_err",  {31'b0, bus_err}, {31'b0, m_err});
        check("err_adr",  err_adr, m_eadr);
    end

    // Called just after a rising edge. ack_after: cycle offset of a one-cycle ext_ack (-1 none);
    // abort_after: offset at which wb_cyc drops (-1 none); clr: err_clr coincident with completion.
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input int ack_after, input int abort_after, input bit clr,
                          output int lat, output int strobes);
        txn_t t;
        int   E;
        E = (cyc_n + 1 > free_at) ? cyc_n + 1 : free_at;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = adr;
        wb_dat_w = wdat;
        wb_sel   = we ? 4'b0011 : 4'b1111;

        t.E = E; t.rgn = tb_region(adr); t.we = we; t.adr = adr; t.wdat = wdat;
        t.sel = wb_sel; t.acks = 1'b1; t.tmo = 1'b0; t.ext_last = -1;
        case (t.rgn)
            0: begin t.endc = E + 1 + TB_MWS; t.rdat = madam_dout; end
            1: begin t.endc = E + 1 + TB_CWS; t.rdat = clio_dout; end
            2: begin t.endc = E; t.rdat = 32'hBADACCE5; end
            3: begin t.endc = E; t.rdat = 32'h0; end
            default: begin
                if (ack_after >= 0 && ack_after < TB_TO) begin
                    t.endc = E + ack_after + 1; t.ext_last = E + ack_after; t.rdat = ext_dat;
                end else begin
                    t.endc = E + TB_TO; t.ext_last = E + TB_TO - 1; t.rdat = 32'hFFFFFFFF;
                    t.tmo = 1'b1;
                end
            end
        endcase
        if (abort_after >= 0) begin
            t.endc = E + abort_after;
            if (t.ext_last > t.endc) t.ext_last = t.endc;
            t.acks = 1'b0;
            t.tmo  = 1'b0;
        end
        q.push_back(t);

        lat = -1;
        strobes = 0;
        while (cyc_n < t.endc) begin
            @(posedge sys_clk);
            #1;
            if (cyc_n == E) begin
                wb_adr   = 32'h0330_0008;
                wb_dat_w = ~wdat;
                wb_stb   = 1'b0;
            end
            if (wb_ack && lat < 0) lat = cyc_n - (E - 1);
            if (madam_rd | madam_wr | clio_rd | clio_wr) strobes++;
            ext_ack = (ack_after >= 0 && cyc_n == E + ack_after);
            if (clr && cyc_n == t.endc - 1) begin
                err_clr = 1'b1;
                clr_at  = t.endc;
            end else begin
                err_clr = 1'b0;
            end
            if (abort_after >= 0 && cyc_n == E + abort_after) begin
                wb_cyc = 1'b0;
                wb_stb = 1'b0;
            end
        end
        ext_ack = 1'b0;
        err_clr = 1'b0;
        free_at = t.endc + 2;
        if (abort_after >= 0) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        clr_at  = cyc_n + 1;
        @(posedge sys_clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int lat, stb, E;
        txn_t t;
        reset = 1'b1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        madam_dout = 32'h12345678; clio_dout = 32'hC1100001;
        ext_ack = 0; ext_dat = '0; err_clr = 0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        free_at = cyc_n + 1;
        idle(1);

        // MADAM read, then back-to-back MADAM write at the top of the window
        do_txn(32'h0330_0004, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        check("madam_rd_lat", 32'(lat), 32'd3);
        check("madam_rd_pulses", 32'(stb), 32'd1);
        check("madam_rdata", wb_dat_r, 32'h12345678);
        do_txn(32'h0330_FFFC, 1'b1, 32'h11112222, -1, -1, 0, lat, stb);

        // CLIO write must leave read data untouched; CLIO read at window top
        do_txn(32'h0340_0100, 1'b1, 32'hA5A5A5A5, -1, -1, 0, lat, stb);
        check("clio_wr_lat", 32'(lat), 32'd4);
        check("clio_wr_pulses", 32'(stb), 32'd1);
        check("clio_tgt_dat", tgt_dat, 32'hA5A5A5A5);
        check("clio_wr_rdata", wb_dat_r, 32'h12345678);
        do_txn(32'h0340_FFFC, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        idle(2);

        // Stubs
        do_txn(32'h0320_6900, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        check("svf_lat", 32'(lat), 32'd1);
        check("svf_pulses", 32'(stb), 32'd0);
        check("svf_rdata", wb_dat_r, 32'hBADACCE5);
        do_txn(32'h0320_02B4, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        check("svf2_rdata", wb_dat_r, 32'h0);
        do_txn(32'h0320_6100, 1'b1, 32'h77777777, -1, -1, 0, lat, stb);
        do_txn(32'h0320_6100, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        idle(1);

        // External accesses just outside the on-chip windows
        ext_dat = 32'h5555AAAA;
        do_txn(32'h0331_0000, 1'b0, 32'h0, 2, -1, 0, lat, stb);
        check("ext_rdata", wb_dat_r, 32'h5555AAAA);
        do_txn(32'h0320_6104, 1'b1, 32'hDEADBEEF, 0, -1, 0, lat, stb);
        idle(1);

        // Timeout, clear, ack coincident with timeout
        do_txn(32'h0000_1000, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        check("tmo_lat", 32'(lat), 32'd5);
        check("tmo_rdata", wb_dat_r, 32'hFFFFFFFF);
        check("tmo_bus_err", {31'b0, bus_err}, 32'd1);
        check("tmo_err_adr", err_adr, 32'h0000_1000);
        idle(1);
        clear_err();
        check("err_clr", {31'b0, bus_err}, 32'd0);
        ext_dat = 32'h0000CAFE;
        do_txn(32'h0000_1800, 1'b0, 32'h0, TB_TO - 1, -1, 0, lat, stb);
        check("coinc_rdata", wb_dat_r, 32'h0000CAFE);
        check("coinc_bus_err", {31'b0, bus_err}, 32'd0);
        do_txn(32'h0000_2000, 1'b0, 32'h0, -1, -1, 1, lat, stb);
        check("clr_prio_bus_err", {31'b0, bus_err}, 32'd0);
        check("clr_prio_err_adr", err_adr, 32'h0000_1000);
        do_txn(32'h0000_3000, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        do_txn(32'h0000_4000, 1'b1, 32'h0BADF00D, -1, -1, 0, lat, stb);
        check("first_err_adr", err_adr, 32'h0000_3000);
        idle(1);

        // Aborts
        do_txn(32'h0340_0200, 1'b0, 32'h0, -1, 1, 0, lat, stb);
        check("clio_abort_ack", 32'(lat), 32'hFFFFFFFF);
        check("clio_abort_pulses", 32'(stb), 32'd1);
        do_txn(32'h0000_5000, 1'b0, 32'h0, -1, 2, 0, lat, stb);
        check("ext_abort_ack", 32'(lat), 32'hFFFFFFFF);
        idle(1);

        // Asynchronous reset in the middle of an external cycle
        E = (cyc_n + 1 > free_at) ? cyc_n + 1 : free_at;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_6000;
        wb_dat_w = 32'h0; wb_sel = 4'hF;
        t.E = E; t.rgn = 4; t.we = 1'b0; t.adr = 32'h0000_6000; t.wdat = 32'h0; t.sel = 4'hF;
        t.acks = 1'b1; t.tmo = 1'b1; t.endc = E + TB_TO; t.ext_last = E + TB_TO - 1;
        t.rdat = 32'hFFFFFFFF;
        q.push_back(t);
        while (cyc_n < E + 1) begin
            @(posedge sys_clk);
            #1;
        end
        check("pre_rst_ext_stb", {31'b0, ext_stb}, 32'd1);
        reset = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        #1;
        check("rst_ext_stb", {31'b0, ext_stb}, 32'd0);
        check("rst_wb_ack", {31'b0, wb_ack}, 32'd0);
        check("rst_tgt_adr", tgt_adr, 32'h0);
        check("rst_wb_dat_r", wb_dat_r, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_err_adr", err_adr, 32'h0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        free_at = cyc_n + 1;
        do_txn(32'h0330_0010, 1'b0, 32'h0, -1, -1, 0, lat, stb);
        check("post_rst_rdata", wb_dat_r, 32'h12345678);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
